draw_sequencer: RTL and testbench
=================================

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 Parameter SCREEN_W, default 160, full-screen width in pixels.
REQ-002 Parameter SCREEN_H, default 120, full-screen height in pixels.
REQ-003 Parameter SPRITE_W, default 40, sprite width in pixels.
REQ-004 Parameter SPRITE_H, default 40, sprite height in pixels.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle draw request; sampled only in IDLE.
REQ-008 fullScreen  in  1  1 = draw SCREEN_W x SCREEN_H image; 0 = draw SPRITE_W x SPRITE_H sprite.
REQ-009 clear  in  1  1 = fill the region with black instead of ROM data.
REQ-010 imageSel  in  5  memory image to draw; latched on accept.
REQ-011 xPosSel / yPosSel  in  4 / 2  sprite origin selects; latched on accept; ignored when fullScreen=1.
REQ-012 busy  out  1  high from accept until done inclusive.
REQ-013 done  out  1  one-cycle pulse after last pixel plotted.
REQ-014 plot  out  1  VGA write enable; x/y/color valid this cycle.
REQ-015 memorySel  out  5; black  out  1; xInitSel  out  4; yInitSel  out  2; xySel  out  2  datapath selects.
REQ-016 xInitLoad, yInitLoad, xReset, yReset, xLoad, yLoad, xCountUp, yCountUp  out  1 each  coordinate register strobes.
REQ-017 addressScreenCounterReset, screenCountLoad, addressSpriteCounterReset, spriteCountLoad  out  1 each  ROM address counter strobes.

Function
REQ-018 FSM states IDLE, INIT, SETUP, DRAW, FLUSH, DONE; exactly one state per cycle.
REQ-019 IDLE: start=1 -> latch fullScreen, clear, imageSel, xPosSel, yPosSel; go INIT; start while not IDLE is ignored, never queued.
REQ-020 INIT (1 cycle): assert xInitLoad, yInitLoad with xInitSel/yInitSel = latched selects (0/0 when fullScreen); go SETUP.
REQ-021 SETUP (1 cycle): assert xReset, yReset (x,y <- xInit,yInit) and the reset of the address counter for the selected mode; go DRAW.
REQ-022 DRAW: each cycle advance the mode's address counter (screenCountLoad or spriteCountLoad) and internal col/row counters; col wraps W-1 -> 0 with row+1.
REQ-023 ROM read latency is 1 cycle: plot, xCountUp, xLoad, yCountUp are the DRAW-cycle pixel events delayed by exactly 1 cycle.
REQ-024 Delayed event for col<W-1: plot=1, xCountUp=1; for col=W-1: plot=1, xLoad=1 and yCountUp=1 in the same cycle.
REQ-025 DRAW exits to FLUSH after issuing pixel (W-1,H-1); FLUSH (1 cycle) emits the final delayed plot; then DONE (done=1, 1 cycle) -> IDLE.
REQ-026 Plot count per request is exactly W*H (19200 screen, 1600 sprite); accept-to-done latency is W*H+4 cycles.
REQ-027 memorySel = latched imageSel and black = latched clear, held constant from INIT through DONE.
REQ-028 Internal counters are 8-bit col, 7-bit row; no wrap beyond H-1 is ever issued.
REQ-029 All strobes not named for a state are 0 in that state; xySel = 2'd0 in IDLE/INIT/SETUP, 2'd1 in DRAW/FLUSH/DONE.

Reset
REQ-030 reset=1 forces IDLE next cycle from any state, including mid-DRAW; no further plot after the reset edge.
REQ-031 Reset values: busy, done, plot, all strobes, black = 0; memorySel, xInitSel, yInitSel, xySel = 0; latched fields and col/row = 0.
REQ-032 reset has priority over start in the same cycle.

Structure
REQ-033 State encoding, SCREEN_/SPRITE_ dimension constants and xySel codes live in the shared game package.
REQ-034 One sub-module, pixel_scan_counter (col/row with wrap and last flags), is instantiated once.

Verification
REQ-035 Sprite: start, fullScreen=0, xPosSel=3, yPosSel=1, imageSel=12 -> 1600 plots, 40 xLoad/yCountUp pairs, done at accept+1604, memorySel=12 throughout.
REQ-036 Full screen: start, fullScreen=1, imageSel=0 -> 19200 plots, 120 row wraps, done at accept+19204.
REQ-037 clear=1 sprite -> black=1 on all 1600 plots, done at accept+1604.
REQ-038 start pulsed at accept+100 during busy -> ignored; exactly one done, plot count unchanged.
REQ-039 reset at accept+500 -> IDLE, busy=0, plot=0 next cycle; fresh start afterwards completes normally.
REQ-040 reset and start in same cycle -> stays IDLE, busy=0.

Source files
------------

// File: rtl/draw_sequencer_pkg.sv
// Shared constants and types for the draw sequencer: FSM states, image
// dimensions and coordinate-mux select codes.
package draw_sequencer_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE_W = 40;
    localparam int SPRITE_H = 40;

    localparam logic [1:0] XY_SEL_INIT = 2'd0;
    localparam logic [1:0] XY_SEL_DRAW = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SETUP,
        S_DRAW,
        S_FLUSH,
        S_DONE
    } state_t;

endpackage

// File: rtl/draw_sequencer_pixel_scan_counter.sv
// Column/row raster scan counter with wrap and last-pixel flags. The counter
// returns to 0,0 after the final pixel so the row never runs past row_max.
module pixel_scan_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [7:0] col_max,
    input  logic [6:0] row_max,
    output logic       last_col,
    output logic       last_pixel
);

    logic [7:0] col;
    logic [6:0] row;
    logic       last_row;

    assign last_col   = (col == col_max);
    assign last_row   = (row == row_max);
    assign last_pixel = last_col && last_row;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 7'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Draw sequencer: walks a full-screen image or a sprite pixel by pixel and
// drives the coordinate/ROM-address datapath strobes and the VGA plot enable.
module draw_sequencer
    import draw_sequencer_pkg::*;
#(
    parameter int SCREEN_W = draw_sequencer_pkg::SCREEN_W,
    parameter int SCREEN_H = draw_sequencer_pkg::SCREEN_H,
    parameter int SPRITE_W = draw_sequencer_pkg::SPRITE_W,
    parameter int SPRITE_H = draw_sequencer_pkg::SPRITE_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       fullScreen,
    input  logic       clear,
    input  logic [4:0] imageSel,
    input  logic [3:0] xPosSel,
    input  logic [1:0] yPosSel,
    output logic       busy,
    output logic       done,
    output logic       plot,
    output logic [4:0] memorySel,
    output logic       black,
    output logic [3:0] xInitSel,
    output logic [1:0] yInitSel,
    output logic [1:0] xySel,
    output logic       xInitLoad,
    output logic       yInitLoad,
    output logic       xReset,
    output logic       yReset,
    output logic       xLoad,
    output logic       yLoad,
    output logic       xCountUp,
    output logic       yCountUp,
    output logic       addressScreenCounterReset,
    output logic       screenCountLoad,
    output logic       addressSpriteCounterReset,
    output logic       spriteCountLoad,
    output state_t     fsm_state
);

    state_t     state_q, state_d;
    logic       full_q, clear_q;
    logic [4:0] image_q;
    logic [3:0] xpos_q;
    logic [1:0] ypos_q;
    logic       pix_valid_q, pix_last_col_q;
    logic       last_col, last_pixel;
    logic [7:0] col_max;
    logic [6:0] row_max;

    assign fsm_state = state_q;
    assign col_max   = full_q ? 8'(SCREEN_W - 1) : 8'(SPRITE_W - 1);
    assign row_max   = full_q ? 7'(SCREEN_H - 1) : 7'(SPRITE_H - 1);

    pixel_scan_counter u_scan (
        .clk        (clk),
        .reset      (reset),
        .clear      (state_q == S_SETUP),
        .advance    (state_q == S_DRAW),
        .col_max    (col_max),
        .row_max    (row_max),
        .last_col   (last_col),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            full_q  <= 1'b0;
            clear_q <= 1'b0;
            image_q <= '0;
            xpos_q  <= '0;
            ypos_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                full_q  <= fullScreen;
                clear_q <= clear;
                image_q <= imageSel;
                xpos_q  <= xPosSel;
                ypos_q  <= yPosSel;
            end
        end
    end

    // ROM data arrives one cycle after the address advances, so every pixel
    // event issued in DRAW is replayed here one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid_q    <= 1'b0;
            pix_last_col_q <= 1'b0;
        end else begin
            pix_valid_q    <= (state_q == S_DRAW);
            pix_last_col_q <= (state_q == S_DRAW) && last_col;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT:  state_d = S_SETUP;
            S_SETUP: state_d = S_DRAW;
            S_DRAW:  if (last_pixel) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy                      = (state_q != S_IDLE);
        done                      = (state_q == S_DONE);
        memorySel                 = busy ? image_q : '0;
        black                     = busy ? clear_q : 1'b0;
        xInitSel                  = '0;
        yInitSel                  = '0;
        xySel                     = XY_SEL_INIT;
        xInitLoad                 = 1'b0;
        yInitLoad                 = 1'b0;
        xReset                    = 1'b0;
        yReset                    = 1'b0;
        yLoad                     = 1'b0;
        addressScreenCounterReset = 1'b0;
        screenCountLoad           = 1'b0;
        addressSpriteCounterReset = 1'b0;
        spriteCountLoad           = 1'b0;
        plot                      = pix_valid_q;
        xCountUp                  = pix_valid_q && !pix_last_col_q;
        xLoad                     = pix_valid_q && pix_last_col_q;
        yCountUp                  = pix_valid_q && pix_last_col_q;
        case (state_q)
            S_INIT: begin
                xInitLoad = 1'b1;
                yInitLoad = 1'b1;
                xInitSel  = full_q ? 4'd0 : xpos_q;
                yInitSel  = full_q ? 2'd0 : ypos_q;
            end
            S_SETUP: begin
                xReset                    = 1'b1;
                yReset                    = 1'b1;
                addressScreenCounterReset = full_q;
                addressSpriteCounterReset = !full_q;
            end
            S_DRAW: begin
                xySel           = XY_SEL_DRAW;
                screenCountLoad = full_q;
                spriteCountLoad = !full_q;
            end
            S_FLUSH, S_DONE: xySel = XY_SEL_DRAW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: per-pixel expectations are queued when a
// request is driven and popped on each observed plot.
module tb_draw_sequencer;
    import draw_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       fullScreen = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] imageSel = '0;
    logic [3:0] xPosSel = '0;
    logic [1:0] yPosSel = '0;
    logic       busy, done, plot, black;
    logic [4:0] memorySel;
    logic [3:0] xInitSel;
    logic [1:0] yInitSel, xySel;
    logic       xInitLoad, yInitLoad, xReset, yReset, xLoad, yLoad, xCountUp, yCountUp;
    logic       addressScreenCounterReset, screenCountLoad, addressSpriteCounterReset, spriteCountLoad;
    state_t     fsm_state;

    // expected plot word: {black, memorySel, end-of-row}
    logic [6:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    draw_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .fullScreen(fullScreen), .clear(clear),
        .imageSel(imageSel), .xPosSel(xPosSel), .yPosSel(yPosSel),
        .busy(busy), .done(done), .plot(plot), .memorySel(memorySel), .black(black),
        .xInitSel(xInitSel), .yInitSel(yInitSel), .xySel(xySel),
        .xInitLoad(xInitLoad), .yInitLoad(yInitLoad), .xReset(xReset), .yReset(yReset),
        .xLoad(xLoad), .yLoad(yLoad), .xCountUp(xCountUp), .yCountUp(yCountUp),
        .addressScreenCounterReset(addressScreenCounterReset), .screenCountLoad(screenCountLoad),
        .addressSpriteCounterReset(addressSpriteCounterReset), .spriteCountLoad(spriteCountLoad),
        .fsm_state(fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drives one request and checks it cycle by cycle. start_at pulses start
    // in that cycle; reset_at asserts reset in that cycle (0 = none).
    task automatic run_request(input logic full, input logic clr, input logic [4:0] img,
                               input logic [3:0] xp, input logic [1:0] yp,
                               input int start_at, input int reset_at);
        int w, h, total, n, plots, wraps, first_plot, dones;
        logic [6:0] e;
        w = full ? SCREEN_W : SPRITE_W;
        h = full ? SCREEN_H : SPRITE_H;
        total = w * h;
        plots = 0; wraps = 0; first_plot = -1; dones = 0;
        exp_q.delete();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                exp_q.push_back({clr, img, (c == w - 1) ? 1'b1 : 1'b0});

        @(negedge clk);
        fullScreen = full; clear = clr; imageSel = img; xPosSel = xp; yPosSel = yp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fullScreen = ~full; clear = ~clr; imageSel = ~img; xPosSel = ~xp; yPosSel = ~yp;
        for (n = 1; n <= total + 8; n++) begin
            if (reset_at != 0 && n == reset_at + 1) begin
                chk("reset_busy", 32'(busy), 32'd0);
                chk("reset_plot", 32'(plot), 32'd0);
                chk("reset_state", 32'(fsm_state), 32'(S_IDLE));
                reset = 1'b0;
                exp_q.delete();
                return;
            end
            chk("busy", 32'(busy), 32'(n <= total + 4));
            chk("done", 32'(done), 32'(n == total + 4));
            dones += int'(done);
            if (n <= total + 4) begin
                chk("memory_sel", 32'(memorySel), 32'(img));
                chk("black", 32'(black), 32'(clr));
            end
            if (n == 1)
                chk("init", {19'd0, xInitLoad, yInitLoad, xInitSel, yInitSel, xySel},
                    {19'd0, 2'b11, full ? 4'd0 : xp, full ? 2'd0 : yp, 2'd0});
            if (n == 2)
                chk("setup", {28'd0, xReset, yReset, addressScreenCounterReset, addressSpriteCounterReset},
                    {28'd0, 2'b11, full, ~full});
            if (n == 3)
                chk("draw", {28'd0, screenCountLoad, spriteCountLoad, xySel}, {28'd0, full, ~full, 2'd1});
            if (plot) begin
                if (first_plot < 0) first_plot = n;
                plots++;
                wraps += int'(xLoad);
                if (exp_q.size() == 0) begin
                    chk("plot_overrun", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", {22'd0, black, memorySel, xLoad, xCountUp, yCountUp, yLoad},
                        {22'd0, e[6], e[5:1], e[0], ~e[0], e[0], 1'b0});
                end
            end else begin
                chk("no_plot_strobes", {29'd0, xLoad, xCountUp, yCountUp}, 32'd0);
            end
            start = (n == start_at);
            if (reset_at != 0 && n == reset_at) reset = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        chk("plot_count", 32'(plots), 32'(total));
        chk("row_wraps", 32'(wraps), 32'(h));
        chk("first_plot_cycle", 32'(first_plot), 32'd4);
        chk("done_count", 32'(dones), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_plot", {30'd0, done, plot}, 32'd0);
        chk("rst_sels", {20'd0, memorySel, black, xInitSel, yInitSel}, 32'd0);
        chk("rst_xy_sel", 32'(xySel), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(S_IDLE));
        reset = 1'b0;

        run_request(1'b0, 1'b0, 5'd12, 4'd3, 2'd1, 0, 0);
        run_request(1'b1, 1'b0, 5'd0, 4'd6, 2'd2, 0, 0);
        run_request(1'b0, 1'b1, 5'd5, 4'd9, 2'd2, 0, 0);
        run_request(1'b0, 1'b0, 5'd7, 4'd1, 2'd3, 100, 0);
        run_request(1'b0, 1'b0, 5'd21, 4'd2, 2'd0, 0, 500);
        run_request(1'b0, 1'b0, 5'd19, 4'd15, 2'd3, 0, 0);
        run_request(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)),
                    4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 0, 0);

        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        imageSel = 5'd9;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        chk("rst_start_state", 32'(fsm_state), 32'(S_IDLE));
        @(negedge clk);
        chk("rst_start_busy_later", 32'(busy), 32'd0);
        chk("rst_start_mem_sel", 32'(memorySel), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
